// File: rtl/mem_arb_pkg.sv
// Shared state encodings and access-size codes for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_I_ADDR,
    S_I_WAIT,
    S_D_ADDR,
    S_D_WAIT
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_arb_hold_buf.sv
// One-word response holding register; valid the cycle after capture.
// Holds until released by pipeline advance or cleared by flush; no backpressure of its own.
module mem_arb_hold_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic [DATA_W-1:0] cap_dat,
  input  logic              rel,
  input  logic              clear,
  output logic              hold_vld,
  output logic [DATA_W-1:0] hold_dat
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_vld <= 1'b0;
      hold_dat <= '0;
    end else begin
      if (clear)        hold_vld <= 1'b0;
      else if (capture) hold_vld <= 1'b1;
      else if (rel)     hold_vld <= 1'b0;
      if (capture && !clear) hold_dat <= cap_dat;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like bus between instruction fetch and MEM-stage load/store; data wins ties.
// Bus request registered one cycle after req, ok one cycle after bus_data_ok; stall_F/stall_M hold the pipe.
// MEM_ARB_PERF_EN adds free-running stall-cycle counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_ok,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_ok,
  input  logic              pipe_stall,
  input  logic              flush,
  output logic              stall_F,
  output logic              stall_M,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_istall_cnt,
  output logic [31:0]       perf_dstall_cnt
`endif
);

  state_t state;
  logic   discard;
  logic   inst_vld;
  logic   data_vld;
  logic   pipe_adv;
  logic   in_inst;
  logic   inst_cap;
  logic   data_cap;

  // Stalls are gated by reset so every output reads 0 while rst is low.
  assign stall_F  = rst & inst_req & ~inst_vld;
  assign stall_M  = rst & data_req & ~data_vld;
  assign inst_ok  = inst_vld;
  assign data_ok  = data_vld;
  assign pipe_adv = ~pipe_stall & ~stall_F & ~stall_M;
  assign in_inst  = (state == S_I_ADDR) || (state == S_I_WAIT);
  assign inst_cap = (state == S_I_WAIT) && bus_data_ok && !discard && !flush;
  assign data_cap = (state == S_D_WAIT) && bus_data_ok && !flush;

  mem_arb_hold_buf #(.DATA_W(DATA_W)) u_inst_buf (
    .clk      (clk),
    .rst      (rst),
    .capture  (inst_cap),
    .cap_dat  (bus_rdata),
    .rel      (pipe_adv),
    .clear    (flush),
    .hold_vld (inst_vld),
    .hold_dat (inst_rdata)
  );

  mem_arb_hold_buf #(.DATA_W(DATA_W)) u_data_buf (
    .clk      (clk),
    .rst      (rst),
    .capture  (data_cap),
    .cap_dat  (bus_rdata),
    .rel      (pipe_adv),
    .clear    (flush),
    .hold_vld (data_vld),
    .hold_dat (data_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      bus_req   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_size  <= SIZE_BYTE;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // A flushed data request belongs to a killed instruction and is never started.
          if (data_req && !data_vld && !flush) begin
            state     <= S_D_ADDR;
            bus_req   <= 1'b1;
            bus_wr    <= data_wr;
            bus_size  <= data_size;
            bus_addr  <= data_addr;
            bus_wdata <= data_wdata;
          end else if (inst_req && !inst_vld && !flush) begin
            state     <= S_I_ADDR;
            bus_req   <= 1'b1;
            bus_wr    <= 1'b0;
            bus_size  <= SIZE_WORD;
            bus_addr  <= inst_addr;
            bus_wdata <= '0;
          end
        end
        S_I_ADDR, S_D_ADDR: begin
          if (bus_addr_ok) begin
            bus_req <= 1'b0;
            bus_wr  <= 1'b0;
            state   <= (state == S_I_ADDR) ? S_I_WAIT : S_D_WAIT;
          end
        end
        S_I_WAIT, S_D_WAIT: begin
          if (bus_data_ok) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // An in-flight fetch that gets flushed still completes on the bus, but its word is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      discard <= 1'b0;
    end else if ((state == S_I_WAIT) && bus_data_ok) begin
      discard <= 1'b0;
    end else if (flush && in_inst) begin
      discard <= 1'b1;
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_istall_cnt <= 32'd0;
      perf_dstall_cnt <= 32'd0;
    end else begin
      if (stall_F) perf_istall_cnt <= perf_istall_cnt + 32'd1;
      if (stall_M) perf_dstall_cnt <= perf_dstall_cnt + 32'd1;
    end
  end
`endif

endmodule
